// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package shift_pkg;

  // Operation codes carried on the 3-bit mode port.
  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_SHL  = 3'd1,
    M_SHR  = 3'd2,
    M_ROL  = 3'd3,
    M_ROR  = 3'd4,
    M_ASR  = 3'd5,
    M_LOAD = 3'd6,
    M_RSVD = 3'd7
  } shift_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // True for codes that start a command; HOLD and the reserved code are no-ops.
  function automatic logic is_cmd(input logic [2:0] m);
    return (m != M_HOLD) && (m != M_RSVD);
  endfunction

  // True for the single-bit shift/rotate codes (everything that walks len steps).
  function automatic logic is_shift(input logic [2:0] m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) ||
           (m == M_ROR) || (m == M_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One single-bit step of the shift register: computes next contents and the bit shifted out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides on which edges the result is registered.
//
// Ports:
//   mode    - operation code (shift_mode_e encoding)
//   cur     - current register contents
//   sin     - serial input bit (ignored by rotates and ASR)
//   nxt     - contents after one step; equals cur for non-shift codes
//   bit_out - bit that leaves the register on this step; 0 for non-shift codes
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] cur,
  input  logic             sin,
  output logic [WIDTH-1:0] nxt,
  output logic             bit_out
);

  always_comb begin
    nxt     = cur;
    bit_out = 1'b0;
    case (shift_mode_e'(mode))
      M_SHL: begin
        nxt     = {cur[WIDTH-2:0], sin};
        bit_out = cur[WIDTH-1];
      end
      M_SHR: begin
        nxt     = {sin, cur[WIDTH-1:1]};
        bit_out = cur[0];
      end
      M_ROL: begin
        nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
        bit_out = cur[WIDTH-1];
      end
      M_ROR: begin
        nxt     = {cur[0], cur[WIDTH-1:1]};
        bit_out = cur[0];
      end
      M_ASR: begin
        // Sign bit is replicated; sin plays no part.
        nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
        bit_out = cur[0];
      end
      default: begin
        // HOLD, LOAD and reserved leave the contents alone; LOAD is handled by the caller.
        nxt     = cur;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-bit shift/rotate bursts under start/busy/done.
// Latency: burst of len=N finishes N-1 cycles after accept (first step on the accepting edge);
//          LOAD and len=0 finish on the accepting edge. done pulses for one cycle afterwards.
// Backpressure: start is only honoured while idle; starts during a burst are dropped, not queued.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset (reset wins over an accepting edge)
//   start    - command request, sampled only in IDLE
//   mode     - operation code, latched on accept
//   len      - number of single-bit steps, latched on accept (may exceed WIDTH)
//   sin      - serial input, sampled on every shift edge
//   pin      - parallel load data
//   out      - register contents
//   sout     - bit that left the register on the most recent shift edge
//   busy     - burst in progress
//   done     - one-cycle completion pulse
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  shift_mode_e      mode_q, mode_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_d;
  logic             sout_d;
  logic             done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_nxt;
  logic             step_bit;
  logic [LEN_W-1:0] len_m1;

  // The step unit is shared: in IDLE it sees the incoming mode so the accepting
  // edge can perform step 1; in RUN it sees the latched mode.
  assign step_mode = (state_q == S_IDLE) ? mode : mode_q;
  assign len_m1    = len - LEN_ONE;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode    (step_mode),
    .cur     (out),
    .sin     (sin),
    .nxt     (step_nxt),
    .bit_out (step_bit)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    out_d   = out;
    sout_d  = sout;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && is_cmd(mode)) begin
          mode_d = shift_mode_e'(mode);
          if (mode == M_LOAD) begin
            // Single-edge load; sout keeps the last shifted-out bit.
            out_d  = pin;
            done_d = 1'b1;
          end else if (is_shift(mode) && (len != '0)) begin
            out_d  = step_nxt;
            sout_d = step_bit;
            rem_d  = len_m1;
            if (len_m1 != '0) begin
              state_d = S_RUN;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            // Zero-length shift: nothing moves, only completion is reported.
            done_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        out_d  = step_nxt;
        sout_d = step_bit;
        rem_d  = rem_q - LEN_ONE;
        if (rem_q == LEN_ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_HOLD;
      rem_q   <= '0;
      out     <= '0;
      sout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      out     <= out_d;
      sout    <= sout_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios followed by random commands, all cycles
// compared against an integer-arithmetic reference model of the register.
// Latency: n/a. Backpressure: n/a.
module tb_univ_shift_reg;

  localparam int W    = 8;
  localparam int LW   = $clog2(W) + 1;
  localparam int MASK = (1 << W) - 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [LW-1:0] len;
  logic          sin;
  logic [W-1:0]  pin;
  logic [W-1:0]  out;
  logic          sout;
  logic          busy;
  logic          done;

  univ_shift_reg #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .len   (len),
    .sin   (sin),
    .pin   (pin),
    .out   (out),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_busy = 0;
  int n_done = 0;

  // Reference model: register value as an integer, pending step count, last mode.
  int m_val  = 0;
  int m_sout = 0;
  int m_left = 0;
  int m_done = 0;
  int m_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One shift step in plain arithmetic on the integer model.
  task automatic apply_op(input int m, input int s);
    int msb;
    int lsb;
    msb = (m_val >> (W - 1)) & 1;
    lsb = m_val & 1;
    case (m)
      1: begin m_sout = msb; m_val = ((m_val * 2) + s) & MASK; end
      2: begin m_sout = lsb; m_val = (m_val / 2) + s * (1 << (W - 1)); end
      3: begin m_sout = msb; m_val = ((m_val * 2) + msb) & MASK; end
      4: begin m_sout = lsb; m_val = (m_val / 2) + lsb * (1 << (W - 1)); end
      5: begin m_sout = lsb; m_val = (m_val / 2) + msb * (1 << (W - 1)); end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic cyc(input int r, input int st, input int md, input int ln,
                     input int s, input int p);
    logic [31:0] tmp;
    rst   = (r != 0);
    start = (st != 0);
    tmp   = md;
    mode  = tmp[2:0];
    tmp   = ln;
    len   = tmp[LW-1:0];
    sin   = (s != 0);
    tmp   = p;
    pin   = tmp[W-1:0];
    @(posedge clk);
    if (r != 0) begin
      m_val = 0; m_sout = 0; m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      apply_op(m_mode, s);
      m_left--;
      m_done = (m_left == 0);
    end else if (st != 0 && md >= 1 && md <= 6) begin
      m_mode = md;
      m_done = 0;
      if (md == 6) begin
        m_val  = p & MASK;
        m_done = 1;
      end else if (ln == 0) begin
        m_done = 1;
      end else begin
        apply_op(md, s);
        m_left = ln - 1;
        m_done = (m_left == 0);
      end
    end else begin
      m_done = 0;
    end
    #1;
    chk("out",  32'(out),  32'(m_val));
    chk("sout", 32'(sout), 32'(m_sout));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    if (busy) n_busy++;
    if (done) n_done++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; len = '0; sin = 1'b0; pin = '0;

    // Reset held while a command is requested: nothing moves.
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 3, 1, 8'hFF);
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    cyc(0, 0, 1, 3, 1, 0);
    cyc(0, 0, 1, 3, 1, 0);
    chk("post_rst_idle", 32'(out), 32'h00);

    // LOAD A5 then SHL 3 with sin=1.
    cyc(0, 1, 6, 0, 0, 8'hA5);
    chk("load_a5", 32'(out), 32'hA5);
    n_busy = 0; n_done = 0;
    cyc(0, 1, 1, 3, 1, 0);
    chk("shl_s1", 32'(out), 32'h4B);
    cyc(0, 0, 0, 0, 1, 0);
    chk("shl_s2", 32'(out), 32'h97);
    cyc(0, 0, 0, 0, 1, 0);
    chk("shl_s3", 32'(out), 32'h2F);
    chk("shl_sout", 32'(sout), 32'h1);
    chk("shl_busy_cnt", 32'(n_busy), 32'd2);
    chk("shl_done_cnt", 32'(n_done), 32'd1);

    // ROR by 1, then back-to-back ROR by WIDTH in the done cycle.
    cyc(0, 1, 6, 0, 0, 8'h81);
    cyc(0, 1, 4, 1, 0, 0);
    chk("ror1", 32'(out), 32'hC0);
    chk("ror1_sout", 32'(sout), 32'h1);
    n_busy = 0; n_done = 0;
    cyc(0, 1, 4, 8, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, i & 1, 0);
    chk("ror8", 32'(out), 32'hC0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ror8_busy_cnt", 32'(n_busy), 32'd7);
    chk("ror8_done_cnt", 32'(n_done), 32'd1);

    // ASR keeps the sign and ignores sin.
    cyc(0, 1, 6, 0, 0, 8'h90);
    cyc(0, 1, 5, 2, 1, 0);
    chk("asr1", 32'(out), 32'hC8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("asr2", 32'(out), 32'hE4);
    chk("asr_sout", 32'(sout), 32'h0);

    // Start during a burst is dropped; then a zero-length shift.
    cyc(0, 1, 6, 0, 0, 8'h3C);
    cyc(0, 1, 1, 4, 0, 0);
    cyc(0, 1, 6, 0, 0, 8'hFF);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("shl4_ignore_load", 32'(out), 32'hC0);
    n_busy = 0; n_done = 0;
    cyc(0, 1, 2, 0, 1, 0);
    chk("len0_out", 32'(out), 32'hC0);
    chk("len0_done", 32'(done), 32'h1);
    chk("len0_busy_cnt", 32'(n_busy), 32'd0);

    // Reset in the middle of a burst: cleared outputs, no completion.
    cyc(0, 1, 6, 0, 0, 8'hFF);
    n_done = 0;
    cyc(0, 1, 2, 5, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("shr_before_rst", 32'(out), 32'h3F);
    cyc(1, 0, 0, 0, 0, 0);
    chk("midrst_out", 32'(out), 32'h00);
    chk("midrst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("midrst_no_done", 32'(n_done), 32'd0);

    // HOLD and reserved codes do nothing.
    cyc(0, 1, 6, 0, 0, 8'h5A);
    n_done = 0;
    cyc(0, 1, 0, 3, 1, 0);
    cyc(0, 1, 7, 3, 1, 0);
    chk("hold_rsvd_out", 32'(out), 32'h5A);
    chk("hold_rsvd_done", 32'(n_done), 32'd0);

    // Random commands, including starts while busy and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0) ? 1 : 0,
          ($urandom_range(0, 9) < 4) ? 1 : 0,
          int'($urandom_range(0, 7)),
          int'($urandom_range(0, (1 << LW) - 1)),
          int'($urandom_range(0, 1)),
          int'($urandom_range(0, MASK)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
